// File: rtl/descramble_lanes.sv
// Multi-bit 100BASE-X descrambler (x^11+x^9+1) with idle-run lock FSM and unlock hold-off timer.
// Optional lock-loss statistics counter enabled by defining DESCRAMBLE_STATS_EN.
module descramble_lanes #(
  parameter int WIDTH            = 2,
  parameter int IDLE_RUN         = 29,
  parameter int UNLOCK_TIME      = 65535,
  parameter int TEST_UNLOCK_TIME = 625,
  localparam int CW              = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] scrambled,
  input  logic [CW-1:0]    scrambled_count,
  input  logic             signal_status,
  input  logic             test_mode,
`ifdef DESCRAMBLE_STATS_EN
  input  logic             stats_clear,
  output logic [15:0]      lock_loss_count,
`endif
  output logic [WIDTH-1:0] descrambled,
  output logic [CW-1:0]    descrambled_count,
  output logic             locked,
  output logic             lock_lost
);

  localparam int RW = $clog2(IDLE_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(IDLE_RUN);
  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);
  localparam logic [15:0]   TIME_NORM = 16'(UNLOCK_TIME);
  localparam logic [15:0]   TIME_TEST = 16'(TEST_UNLOCK_TIME);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state;
  logic [10:0]      lfsr;
  logic [RW-1:0]    run;
  logic [15:0]      timer;

  logic [10:0]      lfsr_nxt;
  logic [RW-1:0]    run_nxt;
  logic [WIDTH-1:0] desc_nxt;
  logic [CW-1:0]    cnt_eff;
  logic             hit;
  logic             key;
  logic             unlock_now;
  logic [15:0]      reload;

  // Walk the valid bits earliest-first; unlocked, the register is loaded with ~in,
  // which equals the transmitter keystream whenever the line carries idle.
  always_comb begin
    lfsr_nxt = lfsr;
    run_nxt  = run;
    desc_nxt = scrambled;
    hit      = 1'b0;
    key      = 1'b0;
    cnt_eff  = (scrambled_count > COUNT_MAX) ? COUNT_MAX : scrambled_count;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i >= WIDTH - int'(cnt_eff)) begin
        key         = lfsr_nxt[8] ^ lfsr_nxt[10];
        desc_nxt[i] = scrambled[i] ^ key;
        lfsr_nxt    = {lfsr_nxt[9:0], (state == LOCKED) ? key : ~scrambled[i]};
        if (desc_nxt[i]) begin
          if (run_nxt < RUN_MAX) run_nxt = run_nxt + RW'(1);
        end else begin
          run_nxt = '0;
        end
        if (run_nxt == RUN_MAX) begin
          hit     = 1'b1;
          run_nxt = '0;
        end
      end
    end
  end

  assign reload     = test_mode ? TIME_TEST : TIME_NORM;
  assign unlock_now = signal_status && (state == LOCKED) && !hit && (timer == 16'd0);

  // Loss of signal detect clears sync like reset but never reports a lock loss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr              <= '0;
      run               <= '0;
      timer             <= '0;
      state             <= UNLOCKED;
      locked            <= 1'b0;
      lock_lost         <= 1'b0;
      descrambled       <= '0;
      descrambled_count <= '0;
    end else begin
      descrambled <= desc_nxt;
      lock_lost   <= 1'b0;
      if (!signal_status) begin
        lfsr              <= '0;
        run               <= '0;
        timer             <= '0;
        state             <= UNLOCKED;
        locked            <= 1'b0;
        descrambled_count <= '0;
      end else begin
        descrambled_count <= cnt_eff;
        lfsr              <= lfsr_nxt;
        run               <= run_nxt;
        case (state)
          UNLOCKED: begin
            if (hit) begin
              state  <= LOCKED;
              locked <= 1'b1;
              timer  <= reload;
            end
          end
          LOCKED: begin
            if (hit) begin
              timer <= reload;
            end else if (timer != 16'd0) begin
              timer <= timer - 16'd1;
            end else begin
              state     <= UNLOCKED;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              run       <= '0;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

`ifdef DESCRAMBLE_STATS_EN
  // Counts on the same edge that raises lock_lost; a clear on that edge wins.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clear) begin
      lock_loss_count <= '0;
    end else if (unlock_now && lock_loss_count != 16'hffff) begin
      lock_loss_count <= lock_loss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_descramble_lanes.sv
// Directed bench for descramble_lanes: WIDTH=2 lock/unlock/reset scenarios and WIDTH=4 variable counts.
// Lock-loss statistics checks are included when DESCRAMBLE_STATS_EN is defined.
module tb_descramble_lanes;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [1:0] scr2;
  logic [1:0] cnt2;
  logic       ss2, tm2;
  logic [1:0] desc2, dcnt2;
  logic       locked2, lost2;

  logic [3:0] scr4;
  logic [2:0] cnt4;
  logic       ss4, tm4;
  logic [3:0] desc4;
  logic [2:0] dcnt4;
  logic       locked4, lost4;

`ifdef DESCRAMBLE_STATS_EN
  logic        stats_clear2, stats_clear4;
  logic [15:0] loss_count2, loss_count4;
`endif

  logic [10:0] tx2, tx4;
  logic [3:0]  last_scr4, last_mask4;
  logic [2:0]  last_cnt4;
  int          checks, failures;

  always #5 clk = ~clk;

  descramble_lanes #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .scrambled(scr2), .scrambled_count(cnt2),
    .signal_status(ss2), .test_mode(tm2),
`ifdef DESCRAMBLE_STATS_EN
    .stats_clear(stats_clear2), .lock_loss_count(loss_count2),
`endif
    .descrambled(desc2), .descrambled_count(dcnt2), .locked(locked2), .lock_lost(lost2)
  );

  descramble_lanes #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .scrambled(scr4), .scrambled_count(cnt4),
    .signal_status(ss4), .test_mode(tm4),
`ifdef DESCRAMBLE_STATS_EN
    .stats_clear(stats_clear4), .lock_loss_count(loss_count4),
`endif
    .descrambled(desc4), .descrambled_count(dcnt4), .locked(locked4), .lock_lost(lost4)
  );

  // Reference additive scrambler: returns {next state, scrambled bit}.
  function automatic logic [11:0] scrStep(input logic [10:0] s, input logic p);
    logic k;
    k = s[8] ^ s[10];
    return {s[9:0], k, p ^ k};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat on both lanes: dut2 gets two plain bits, dut4 gets c4 idle bits plus random filler.
  task automatic applyStimulus(input logic [1:0] plain2, input logic [2:0] c4);
    logic [11:0] r;
    logic [3:0]  s4, m4;
    int          ceff;
    for (int i = 1; i >= 0; i--) begin
      r       = scrStep(tx2, plain2[i]);
      tx2     = r[11:1];
      scr2[i] = r[0];
    end
    s4   = 4'($urandom);
    m4   = 4'h0;
    ceff = (int'(c4) > 4) ? 4 : int'(c4);
    for (int i = 3; i >= 0; i--) begin
      if (i >= 4 - ceff) begin
        r     = scrStep(tx4, 1'b1);
        tx4   = r[11:1];
        s4[i] = r[0];
        m4[i] = 1'b1;
      end
    end
    scr4       = s4;
    cnt4       = c4;
    last_scr4  = s4;
    last_mask4 = m4;
    last_cnt4  = 3'(ceff);
    @(posedge clk);
    #1;
  endtask

  task automatic runAcquire();
    rst_n = 1'b0;
    applyStimulus(2'b11, 3'd0);
    checkOutput("rst_locked", 32'(locked2), 32'd0);
    checkOutput("rst_lost", 32'(lost2), 32'd0);
    checkOutput("rst_desc", 32'(desc2), 32'd0);
    checkOutput("rst_dcnt", 32'(dcnt2), 32'd0);
    rst_n = 1'b1;
    tx2   = 11'h5a5;
    for (int b = 0; b < 21; b++) begin
      applyStimulus(2'b11, 3'd0);
      case (b)
        0: begin
          checkOutput("acq_desc_b0", 32'(desc2), 32'h2);
          checkOutput("acq_dcnt_b0", 32'(dcnt2), 32'd2);
        end
        1:  checkOutput("acq_desc_b1", 32'(desc2), 32'h1);
        4:  checkOutput("acq_desc_b4", 32'(desc2), 32'h3);
        5:  checkOutput("acq_desc_b5", 32'(desc2), 32'h1);
        18: checkOutput("acq_unlocked_b18", 32'(locked2), 32'd0);
        19: begin
          checkOutput("acq_locked_b19", 32'(locked2), 32'd1);
          checkOutput("acq_desc_b19", 32'(desc2), 32'h3);
        end
        20: begin
          checkOutput("acq_locked_b20", 32'(locked2), 32'd1);
          checkOutput("acq_desc_b20", 32'(desc2), 32'h3);
        end
        default: ;
      endcase
    end
  endtask

  // Forces a hit on a known beat, then zeros every 20 bits until the hold-off expires.
  task automatic drainFromHit(input bit clear_at_pulse);
    applyStimulus(2'b01, 3'd0);
    repeat (14) applyStimulus(2'b11, 3'd0);
    for (int j = 1; j <= 627; j++) begin
`ifdef DESCRAMBLE_STATS_EN
      stats_clear2 = clear_at_pulse && (j == 626);
`endif
      applyStimulus((j % 10 == 0) ? 2'b10 : 2'b11, 3'd0);
      if (j == 10) checkOutput("drain_desc_zero", 32'(desc2), 32'h2);
      if (j == 625) begin
        checkOutput("drain_locked_625", 32'(locked2), 32'd1);
        checkOutput("drain_lost_625", 32'(lost2), 32'd0);
      end
      if (j == 626) begin
        checkOutput("drain_lost_626", 32'(lost2), 32'd1);
        checkOutput("drain_locked_626", 32'(locked2), 32'd0);
`ifdef DESCRAMBLE_STATS_EN
        if (clear_at_pulse) checkOutput("stats_clear_wins", 32'(loss_count2), 32'd0);
`endif
      end
      if (j == 627) checkOutput("drain_lost_627", 32'(lost2), 32'd0);
    end
`ifdef DESCRAMBLE_STATS_EN
    stats_clear2 = 1'b0;
`endif
  endtask

  task automatic relock();
    repeat (25) applyStimulus(2'b11, 3'd0);
    checkOutput("relock", 32'(locked2), 32'd1);
  endtask

  initial begin
    logic [2:0] seq [4];
    bit         saw_pulse;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    scr2 = '0; cnt2 = 2'd2; ss2 = 1'b1; tm2 = 1'b0;
    scr4 = '0; cnt4 = 3'd0; ss4 = 1'b1; tm4 = 1'b0;
    tx2  = 11'h5a5;
    tx4  = 11'h5a5;
`ifdef DESCRAMBLE_STATS_EN
    stats_clear2 = 1'b0;
    stats_clear4 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;

    runAcquire();

    tm2 = 1'b1;
    drainFromHit(1'b0);

    tm2 = 1'b0;
    relock();
    ss2 = 1'b0;
    applyStimulus(2'b11, 3'd0);
    checkOutput("sd_locked", 32'(locked2), 32'd0);
    checkOutput("sd_lost", 32'(lost2), 32'd0);
    checkOutput("sd_dcnt", 32'(dcnt2), 32'd0);
    ss2       = 1'b1;
    saw_pulse = 1'b0;
    for (int b = 0; b < 20; b++) begin
      applyStimulus(2'b11, 3'd0);
      if (lost2) saw_pulse = 1'b1;
      if (b == 13) checkOutput("sd_no_early_lock", 32'(locked2), 32'd0);
    end
    checkOutput("sd_relocked", 32'(locked2), 32'd1);
    checkOutput("sd_no_pulse", 32'(saw_pulse), 32'd0);

    runAcquire();

`ifdef DESCRAMBLE_STATS_EN
    tm2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drainFromHit(1'b0);
      checkOutput("stats_count", 32'(loss_count2), 32'(k + 1));
      relock();
    end
    checkOutput("stats_three", 32'(loss_count2), 32'd3);
    drainFromHit(1'b1);
    checkOutput("stats_after_clear", 32'(loss_count2), 32'd0);
    tm2 = 1'b0;
`endif

    seq[0] = 3'd4; seq[1] = 3'd3; seq[2] = 3'd0; seq[3] = 3'd1;
    for (int b = 0; b < 24; b++) applyStimulus(2'b11, seq[b % 4]);
    checkOutput("w4_locked", 32'(locked4), 32'd1);
    for (int b = 0; b < 8; b++) begin
      applyStimulus(2'b11, seq[b % 4]);
      checkOutput("w4_dcnt", 32'(dcnt4), 32'(last_cnt4));
      checkOutput("w4_desc", 32'(desc4), 32'((last_scr4 & ~last_mask4) | last_mask4));
    end
    applyStimulus(2'b11, 3'd7);
    checkOutput("w4_over_dcnt", 32'(dcnt4), 32'd4);
    checkOutput("w4_over_desc", 32'(desc4), 32'hf);
    checkOutput("w4_still_locked", 32'(locked4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
